matrix_input_parser: RTL
========================

Name: matrix_input_parser

Overview:
- UART-receive-side ASCII parser for matrix entry; the inbound counterpart of the matrix listing/display path.
- Consumes bytes from uart_rx, tokenises decimal numbers, validates dimensions and element values, and emits a row-major write stream into multi_matrix_storage.
- Text format: "rows cols e11 e12 ... eRC". Separators are space (0x20), CR (0x0D) and LF (0x0A). Any separator can appear anywhere, and runs of separators collapse.

Parameters:
- MAX_SIZE, 5, max rows/cols accepted (1..MAX_SIZE).
- DATA_WIDTH, 8, element width on the write port.
- ELEM_MAX, 9, largest legal element value.
- TIMEOUT_CYCLES, 100000000, inter-byte timeout (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  parser enabled; bytes are ignored while low
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- busy  out  1  a matrix is being parsed
- mat_begin  out  1  one-cycle pulse, dimensions accepted
- mat_rows  out  3  accepted rows, held until next mat_begin
- mat_cols  out  3  accepted cols, held until next mat_begin
- wr_en  out  1  one-cycle element write strobe
- wr_row  out  3  element row, 1-based
- wr_col  out  3  element col, 1-based
- wr_data  out  DATA_WIDTH  element value
- mat_done  out  1  one-cycle pulse on the final element write
- err  out  1  one-cycle error pulse
- err_code  out  3  1=illegal char, 2=bad dimension, 3=element>ELEM_MAX, 4=timeout; held until next err

Behaviour:
- Reset (async, rst=1): all outputs 0; state S_IDLE; accumulator, token flag, indices cleared. Reset asserted mid-parse discards everything, with no pulses.
- Char classes: digit 0x30-0x39; separator; anything else is illegal.
- Accumulator: acc <= acc*10 + digit. acc is 8 bits and saturates at 255. Leading zeros are legal ("05" = 5). in_tok sets on the first digit.
- A token closes on a separator while in_tok=1. Separators while in_tok=0 are ignored.
- All outputs are registered. Every pulse occurs the cycle after the rx_valid of the triggering byte.
- States:
  - S_IDLE: busy=0. The first digit loads acc, sets busy=1 and moves to S_ROWS. Separators are ignored. An illegal char raises err code 1 and moves to S_FLUSH.
  - S_ROWS: on close, if acc is in 1..MAX_SIZE, latch rows and go to S_COLS. Otherwise raise err code 2 and go to S_FLUSH.
  - S_COLS: on close, validate the same way. If valid: mat_rows/mat_cols update, mat_begin pulses, wr_row=1, wr_col=1, go to S_ELEM.
  - S_ELEM: on close, if acc<=ELEM_MAX, wr_en pulses with the current wr_row/wr_col and wr_data=acc. Then the column advances; on a column wrap the row increments and col returns to 1. On the close at (rows,cols), mat_done pulses together with wr_en, busy drops and the state returns to S_IDLE. If acc>ELEM_MAX: err code 3, no write, go to S_FLUSH.
  - S_FLUSH: busy=0. Discards bytes until LF, then goes to S_IDLE. If LF itself is the erroring terminator, the next state is S_IDLE directly.
- An illegal char in any parsing state gives err code 1 and S_FLUSH. Writes already issued are not retracted.
- en low: rx_valid is ignored. If en falls while busy, abort silently to S_IDLE on the next cycle (busy=0, no err).
- wr_en, mat_begin and err are mutually exclusive within a cycle. mat_done occurs only together with wr_en.
- The index counters never exceed mat_rows/mat_cols.

Optional Feature:
- Macro: PARSER_TIMEOUT_EN.
- Defined: a counter runs while busy=1 and clears on every rx_valid. On reaching TIMEOUT_CYCLES it raises err code 4 and returns to S_IDLE, not S_FLUSH.
- Undefined: no counter. The parser waits indefinitely, and code 4 is never produced.

Test Plan:
- Input "2 3\n1 2 3\n4 5 6\n" -> mat_begin with rows=2, cols=3. Six wr_en strobes (1,1)=1, (1,2)=2, (1,3)=3, (2,1)=4, (2,2)=5, (2,3)=6. mat_done coincides with the (2,3) write; busy=0 afterwards.
- Input "  1   1 \r\n7 " -> separators collapse. One write (1,1)=7 with mat_done. No err.
- Input "6 2\n" -> err code 2 after the "6" token closes, no mat_begin. Then input "1 1 3 " -> a normal (1,1)=3 write.
- Input "2 2 1 12 ..." -> writes (1,1)=1, then err code 3 at the "12" token. Bytes up to LF are discarded, with no further wr_en.
- Input "2 a" -> err code 1. Assert rst mid-stream after "3 3 1 " -> all outputs 0 and the next "1 1 5 " parses cleanly.
- With PARSER_TIMEOUT_EN and TIMEOUT_CYCLES=50: send "2 2 1 " then idle 50 cycles -> err code 4 and busy=0. Without the macro, no err.

Source files
------------

// File: rtl/matrix_input_parser_if.sv
// Byte-in / matrix-write-out bundle for matrix_input_parser.
// The slave modport is the parser side and the master modport is the UART/storage side.
interface matrix_input_parser_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  en;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  busy;
    logic                  mat_begin;
    logic [2:0]            mat_rows;
    logic [2:0]            mat_cols;
    logic                  wr_en;
    logic [2:0]            wr_row;
    logic [2:0]            wr_col;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  mat_done;
    logic                  err;
    logic [2:0]            err_code;

    modport slave (
        input  en, rx_valid, rx_data,
        output busy, mat_begin, mat_rows, mat_cols, wr_en, wr_row, wr_col,
               wr_data, mat_done, err, err_code
    );

    modport master (
        output en, rx_valid, rx_data,
        input  busy, mat_begin, mat_rows, mat_cols, wr_en, wr_row, wr_col,
               wr_data, mat_done, err, err_code
    );
endinterface

// File: rtl/matrix_input_parser.sv
// ASCII "rows cols e11 ... eRC" parser that turns UART bytes into a row-major matrix write stream.
// Optional inter-byte timeout (error code 4) is enabled by defining PARSER_TIMEOUT_EN.
module matrix_input_parser #(
    parameter int MAX_SIZE       = 5,
    parameter int DATA_WIDTH     = 8,
    parameter int ELEM_MAX       = 9,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic                  clk,
    input  logic                  rst,
    matrix_input_parser_if.slave  pif
);
    typedef enum logic [2:0] {S_IDLE, S_ROWS, S_COLS, S_ELEM, S_FLUSH} state_t;

    state_t      state_r;
    logic [7:0]  acc_r;
    logic        in_tok_r;
    logic [2:0]  rows_r;
    logic [2:0]  row_idx_r;
    logic [2:0]  col_idx_r;

    logic        is_digit_s;
    logic        is_sep_s;
    logic        is_lf_s;
    logic [11:0] acc_wide_s;
    logic [7:0]  acc_next_s;
    logic        dim_ok_s;
    logic        elem_ok_s;
    logic        last_s;
    logic        timeout_s;

    // Byte classification, saturating accumulate and token validation
    always_comb begin
        is_digit_s = (pif.rx_data >= 8'h30) && (pif.rx_data <= 8'h39);
        is_lf_s    = (pif.rx_data == 8'h0A);
        is_sep_s   = (pif.rx_data == 8'h20) || (pif.rx_data == 8'h0D) || is_lf_s;
        acc_wide_s = ({4'd0, acc_r} * 12'd10) + {8'd0, pif.rx_data[3:0]};
        if (acc_wide_s > 12'd255) begin
            acc_next_s = 8'hFF;
        end else begin
            acc_next_s = acc_wide_s[7:0];
        end
        dim_ok_s  = (acc_r >= 8'd1) && (acc_r <= 8'(MAX_SIZE));
        elem_ok_s = (acc_r <= 8'(ELEM_MAX));
        last_s    = (row_idx_r == pif.mat_rows) && (col_idx_r == pif.mat_cols);
    end

`ifdef PARSER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_r;

    // Idle-gap counter: runs only while a matrix is in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (!pif.busy || !pif.en || pif.rx_valid || timeout_s) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end
    end

    assign timeout_s = pif.busy && pif.en && !pif.rx_valid &&
                       (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Parser FSM with all outputs registered; pulses default low every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            acc_r         <= 8'd0;
            in_tok_r      <= 1'b0;
            rows_r        <= 3'd0;
            row_idx_r     <= 3'd0;
            col_idx_r     <= 3'd0;
            pif.busy      <= 1'b0;
            pif.mat_begin <= 1'b0;
            pif.mat_rows  <= 3'd0;
            pif.mat_cols  <= 3'd0;
            pif.wr_en     <= 1'b0;
            pif.wr_row    <= 3'd0;
            pif.wr_col    <= 3'd0;
            pif.wr_data   <= {DATA_WIDTH{1'b0}};
            pif.mat_done  <= 1'b0;
            pif.err       <= 1'b0;
            pif.err_code  <= 3'd0;
        end else begin
            pif.mat_begin <= 1'b0;
            pif.wr_en     <= 1'b0;
            pif.mat_done  <= 1'b0;
            pif.err       <= 1'b0;
            if (!pif.en) begin
                // Silent abort: an in-progress matrix is dropped without an error
                if (pif.busy) begin
                    state_r  <= S_IDLE;
                    pif.busy <= 1'b0;
                    acc_r    <= 8'd0;
                    in_tok_r <= 1'b0;
                end
            end else if (timeout_s) begin
                state_r      <= S_IDLE;
                pif.busy     <= 1'b0;
                acc_r        <= 8'd0;
                in_tok_r     <= 1'b0;
                pif.err      <= 1'b1;
                pif.err_code <= 3'd4;
            end else if (pif.rx_valid) begin
                case (state_r)
                    S_IDLE: begin
                        if (is_digit_s) begin
                            acc_r    <= {4'd0, pif.rx_data[3:0]};
                            in_tok_r <= 1'b1;
                            pif.busy <= 1'b1;
                            state_r  <= S_ROWS;
                        end else if (!is_sep_s) begin
                            pif.err      <= 1'b1;
                            pif.err_code <= 3'd1;
                            state_r      <= S_FLUSH;
                        end
                    end
                    S_ROWS, S_COLS, S_ELEM: begin
                        if (is_digit_s) begin
                            acc_r    <= acc_next_s;
                            in_tok_r <= 1'b1;
                        end else if (!is_sep_s) begin
                            pif.err      <= 1'b1;
                            pif.err_code <= 3'd1;
                            pif.busy     <= 1'b0;
                            acc_r        <= 8'd0;
                            in_tok_r     <= 1'b0;
                            state_r      <= S_FLUSH;
                        end else if (in_tok_r) begin
                            acc_r    <= 8'd0;
                            in_tok_r <= 1'b0;
                            if (state_r == S_ELEM ? !elem_ok_s : !dim_ok_s) begin
                                // An LF that closes a bad token already ends the line
                                pif.err      <= 1'b1;
                                pif.err_code <= (state_r == S_ELEM) ? 3'd3 : 3'd2;
                                pif.busy     <= 1'b0;
                                state_r      <= is_lf_s ? S_IDLE : S_FLUSH;
                            end else if (state_r == S_ROWS) begin
                                rows_r  <= acc_r[2:0];
                                state_r <= S_COLS;
                            end else if (state_r == S_COLS) begin
                                pif.mat_rows  <= rows_r;
                                pif.mat_cols  <= acc_r[2:0];
                                pif.mat_begin <= 1'b1;
                                pif.wr_row    <= 3'd1;
                                pif.wr_col    <= 3'd1;
                                row_idx_r     <= 3'd1;
                                col_idx_r     <= 3'd1;
                                state_r       <= S_ELEM;
                            end else begin
                                pif.wr_en   <= 1'b1;
                                pif.wr_row  <= row_idx_r;
                                pif.wr_col  <= col_idx_r;
                                pif.wr_data <= DATA_WIDTH'(acc_r);
                                if (last_s) begin
                                    pif.mat_done <= 1'b1;
                                    pif.busy     <= 1'b0;
                                    row_idx_r    <= 3'd1;
                                    col_idx_r    <= 3'd1;
                                    state_r      <= S_IDLE;
                                end else if (col_idx_r == pif.mat_cols) begin
                                    col_idx_r <= 3'd1;
                                    row_idx_r <= row_idx_r + 3'd1;
                                end else begin
                                    col_idx_r <= col_idx_r + 3'd1;
                                end
                            end
                        end
                    end
                    S_FLUSH: begin
                        if (is_lf_s) begin
                            state_r <= S_IDLE;
                        end
                    end
                    default: begin
                        state_r  <= S_IDLE;
                        pif.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
